// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter sharing one unified MEM between the multicycle
//            core (m0) and a loader/debug master (m1). Serializes accesses,
//            drives the MEM strobes, address and write data, and returns read
//            data with a one-cycle completion pulse. Round-robin fairness with
//            an optional per-master lock that is capped at LOCK_MAX
//            consecutive grants while the other master is waiting.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state on the rising edge
//   rst        in   asynchronous active-low reset
//   mN_req     in   access request, held until mN_done
//   mN_we      in   1 = write, 0 = read
//   mN_addr    in   access address                    [AW]
//   mN_wdata   in   write data                        [DW]
//   mN_lock    in   keep the grant for the next access
//   mN_gnt     out  master N owns MEM
//   mN_done    out  one-cycle completion pulse
//   mN_rdata   out  read data, valid with mN_done     [DW]
//   mem_addr   out  MEM address                       [AW]
//   mem_W      out  MEM write strobe
//   mem_R      out  MEM read strobe
//   mem_wdata  out  MEM write data                    [DW]
//   mem_rdata  in   MEM read data                     [DW]
//   busy       out  arbiter not idle
//   owner      out  current/last owner (0 = m0, 1 = m1)
// ============================================================================
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_W,
  output logic          mem_R,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int HW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [HW-1:0] C_HOLD_MAX  = HW'(LOCK_MAX - 1);
  localparam logic [CW-1:0] C_WAIT_INIT = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_owner;
  logic            r_rr;        // 0 favours m0, 1 favours m1
  logic [HW-1:0]   r_hold;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;

  logic            w_any_req;
  logic            w_own_req;
  logic            w_own_lock;
  logic            w_oth_req;
  logic            w_cont;
  logic            w_ptr;
  logic            w_win;
  logic            w_arb;
  logic            w_sel_we;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign w_any_req  = m0_req | m1_req;
  assign w_own_req  = r_owner ? m1_req  : m0_req;
  assign w_own_lock = r_owner ? m1_lock : m0_lock;
  assign w_oth_req  = r_owner ? m0_req  : m1_req;

  // Locked continuation: owner keeps MEM unless the other master is waiting
  // and the owner has already used its full run of consecutive grants.
  assign w_cont = (r_state == S_DONE) && w_own_req && w_own_lock &&
                  !(w_oth_req && (r_hold == C_HOLD_MAX));

  // The access completing in DONE already moves the pointer away from its
  // owner, so the re-arbitration in that same cycle must see the new value.
  assign w_ptr = (r_state == S_DONE) ? ~r_owner : r_rr;

  always_comb begin
    w_win = 1'b0;
    if (w_cont) begin
      w_win = r_owner;
    end else if (m0_req && m1_req) begin
      w_win = w_ptr;
    end else begin
      w_win = m1_req;
    end
  end

  assign w_arb = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_any_req;

  assign w_sel_we    = w_win ? m1_we    : m0_we;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: w_next = r_we ? S_DONE : S_WAIT;
      S_WAIT:   if (r_wait_cnt == '0) w_next = S_DONE;
      S_DONE:   w_next = w_any_req ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant bookkeeping: owner, latched access fields, pointer, lock counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_arb) begin
      r_owner <= w_win;
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= 1'b0;
    end else if ((r_state == S_DONE) && !w_cont) begin
      r_rr <= ~r_owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if ((r_state == S_DONE) && !w_any_req) begin
      r_hold <= '0;
    end else if (w_arb) begin
      if (w_cont) begin
        if (r_hold != C_HOLD_MAX) r_hold <= r_hold + 1'b1;
      end else if (w_win != r_owner) begin
        r_hold <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read latency counter and per-master read data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ACCESS) begin
      r_wait_cnt <= C_WAIT_INIT;
    end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if ((r_state == S_WAIT) && (r_wait_cnt == '0)) begin
      if (r_owner) r_rdata1 <= mem_rdata;
      else         r_rdata0 <= mem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state so an async reset clears them
  // immediately.
  // --------------------------------------------------------------------------
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign m0_gnt    = busy && !r_owner;
  assign m1_gnt    = busy &&  r_owner;
  assign m0_done   = (r_state == S_DONE) && !r_owner;
  assign m1_done   = (r_state == S_DONE) &&  r_owner;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_W     = (r_state == S_ACCESS) &&  r_we;
  assign mem_R     = (r_state == S_ACCESS) && !r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter. Instance A uses RD_LAT=1,
//            instance B uses RD_LAT=3. Each instance has a small MEM model
//            whose read data is valid only in the exact cycle the arbiter
//            should capture it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A signals ----------------
  logic        a_m0_req = 0, a_m0_we = 0, a_m0_lock = 0;
  logic        a_m1_req = 0, a_m1_we = 0, a_m1_lock = 0;
  logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
  logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done;
  logic        a_mem_W, a_mem_R, a_busy, a_owner;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  // ---------------- instance B signals ----------------
  logic        b_m0_req = 0, b_m0_we = 0, b_m0_lock = 0;
  logic        b_m1_req = 0, b_m1_we = 0, b_m1_lock = 0;
  logic [31:0] b_m0_addr = 0, b_m0_wdata = 0, b_m1_addr = 0, b_m1_wdata = 0;
  logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done;
  logic        b_mem_W, b_mem_R, b_busy, b_owner;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .LOCK_MAX(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_lock(a_m0_lock), .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_lock(a_m1_lock), .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
    .mem_addr(a_mem_addr), .mem_W(a_mem_W), .mem_R(a_mem_R), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .LOCK_MAX(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_lock(b_m0_lock), .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_lock(b_m1_lock), .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_W(b_mem_W), .mem_R(b_mem_R), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  // ---------------- MEM models: word i holds 0xA0000000+i after reset -------
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic        va [4];
  logic        vb [4];
  logic [5:0]  aa [4];
  logic [5:0]  ab [4];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'hA000_0000 + i;
        mem_b[i] <= 32'hA000_0000 + i;
      end
      for (int k = 0; k < 4; k++) begin
        va[k] <= 1'b0; vb[k] <= 1'b0; aa[k] <= '0; ab[k] <= '0;
      end
    end else begin
      if (a_mem_W) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
      if (b_mem_W) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
      va[0] <= a_mem_R; aa[0] <= a_mem_addr[7:2];
      vb[0] <= b_mem_R; ab[0] <= b_mem_addr[7:2];
      for (int k = 1; k < 4; k++) begin
        va[k] <= va[k-1]; aa[k] <= aa[k-1];
        vb[k] <= vb[k-1]; ab[k] <= ab[k-1];
      end
    end
  end

  assign a_mem_rdata = va[0] ? mem_a[aa[0]] : 32'h0BAD_0BAD;
  assign b_mem_rdata = vb[2] ? mem_b[ab[2]] : 32'h0BAD_0BAD;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;   // 0 = do not check completion cycle
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int          w_cnt = 0, r_cnt = 0, w_cyc = 0, r_cyc = 0;
  logic [31:0] w_addr = 0, w_data = 0, r_addr = 0;

  // Monitor for instance A: strobe tracking and scoreboard comparison.
  always @(negedge clk) begin
    if (rst) chk("strobe_excl", {63'b0, a_mem_W & a_mem_R}, 64'd0);
    if (a_mem_W) begin
      w_cnt++; w_cyc = cyc; w_addr = a_mem_addr; w_data = a_mem_wdata;
    end
    if (a_mem_R) begin
      r_cnt++; r_cyc = cyc; r_addr = a_mem_addr;
    end
    if (a_m0_done || a_m1_done) begin
      chk("done_excl", {63'b0, a_m0_done & a_m1_done}, 64'd0);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done m0=%0d m1=%0d, expected none", a_m0_done, a_m1_done);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_port", {63'b0, a_m1_done}, {63'b0, mon_e.port});
        if (mon_e.rd) chk("rdata", mon_e.port ? a_m1_rdata : a_m0_rdata, mon_e.data);
        if (mon_e.cyc != 0) chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for n completion pulses on instance A; returns at the
  // falling edge of the n-th DONE cycle.
  task automatic wait_done(input int n);
    int got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      @(negedge clk);
      if (a_m0_done || a_m1_done) got++;
    end
    chk("wait_done", got, n);
  endtask

  // Single access on instance A starting from IDLE.
  task automatic do_access(input bit p, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    int n, wc, rc;
    n = cyc; wc = w_cnt; rc = r_cnt;
    sbq.push_back('{p, !we, exp_rd, we ? n + 2 : n + 3});
    if (!p) begin
      a_m0_req = 1; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd;
    end else begin
      a_m1_req = 1; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd;
    end
    wait_done(1);
    a_m0_req = 0; a_m1_req = 0;
    if (we) begin
      chk("w_strobes", w_cnt - wc, 1);
      chk("w_cycle", w_cyc, n + 1);
      chk("w_addr", w_addr, addr);
      chk("w_data", w_data, wd);
      chk("r_strobes", r_cnt - rc, 0);
    end else begin
      chk("r_strobes", r_cnt - rc, 1);
      chk("r_cycle", r_cyc, n + 1);
      chk("r_addr", r_addr, addr);
      chk("w_strobes", w_cnt - wc, 0);
    end
    tick();
  endtask

  // Single read on instance B (RD_LAT=3) starting from IDLE: DONE in cycle 5.
  task automatic b_read(input bit p, input logic [31:0] addr, input logic [31:0] exp_rd);
    int n;
    bit seen = 0;
    n = cyc;
    if (!p) begin b_m0_req = 1; b_m0_we = 0; b_m0_addr = addr; end
    else    begin b_m1_req = 1; b_m1_we = 0; b_m1_addr = addr; end
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (b_m0_done || b_m1_done) seen = 1;
    end
    chk("b_done_seen", {63'b0, seen}, 64'd1);
    chk("b_done_cycle", cyc, n + 5);
    chk("b_done_port", {63'b0, b_m1_done}, {63'b0, p});
    chk("b_rdata", p ? b_m1_rdata : b_m0_rdata, exp_rd);
    b_m0_req = 0; b_m1_req = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {56'b0, a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done,
                       a_mem_W, a_mem_R, a_busy, a_owner}, 64'd0);
    chk("reset_data", {32'b0, a_mem_addr | a_mem_wdata | a_m0_rdata | a_m1_rdata}, 64'd0);
    rst = 1;
    tick();

    // ---- reset in the middle of a read ----
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h10;
    tick();
    tick();
    chk("wait_state", {61'b0, a_busy, a_m0_gnt, a_mem_R}, 64'b110);
    #1 rst = 0;
    #1 chk("async_reset", {60'b0, a_busy, a_m0_gnt, a_mem_R, a_mem_W}, 64'd0);
    a_m0_req = 0;
    tick();
    rst = 1;
    tick();
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 32'hA000_0004);

    // ---- write then read back ----
    do_access(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0);
    do_access(1'b0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF);
    chk("m1_rdata_quiet", a_m1_rdata, 64'd0);

    // ---- simultaneous requests from reset: alternate, no bubble ----
    rst = 0;
    tick();
    rst = 1;
    tick();
    n = cyc;
    sbq.push_back('{1'b0, 1'b1, 32'hA000_000C, n + 3});
    sbq.push_back('{1'b1, 1'b1, 32'hA000_000D, n + 6});
    sbq.push_back('{1'b0, 1'b1, 32'hA000_000C, n + 9});
    sbq.push_back('{1'b1, 1'b1, 32'hA000_000D, n + 12});
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h30;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h34;
    wait_done(4);
    a_m0_req = 0; a_m1_req = 0;
    tick();

    // ---- lock starvation cap: 8 locked m0 grants, then forced m1 ----
    n = cyc;
    for (int k = 1; k <= 8; k++) sbq.push_back('{1'b0, 1'b1, 32'hA000_0010, n + 3 * k});
    sbq.push_back('{1'b1, 1'b1, 32'hA000_0011, n + 27});
    sbq.push_back('{1'b0, 1'b1, 32'hA000_0010, n + 30});
    a_m0_req = 1; a_m0_we = 0; a_m0_addr = 32'h40; a_m0_lock = 1;
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h44;
    wait_done(9);
    a_m1_req = 0;
    wait_done(1);
    a_m0_req = 0; a_m0_lock = 0;
    tick();

    // ---- request dropped during WAIT still completes once ----
    n = cyc;
    sbq.push_back('{1'b1, 1'b1, 32'hA000_0012, n + 3});
    a_m1_req = 1; a_m1_we = 0; a_m1_addr = 32'h48;
    tick();
    tick();
    a_m1_req = 0;
    wait_done(1);
    tick();
    chk("idle_after_drop", {61'b0, a_busy, a_m0_gnt, a_m1_gnt}, 64'd0);
    chk("owner_kept", {63'b0, a_owner}, 64'd1);
    repeat (3) tick();
    chk("still_idle", {63'b0, a_busy}, 64'd0);

    // ---- RD_LAT=3 instance ----
    b_read(1'b0, 32'h10, 32'hA000_0004);
    b_read(1'b1, 32'h44, 32'hA000_0011);
    chk("b_m0_rdata_kept", b_m0_rdata, 64'hA000_0004);

    repeat (3) tick();
    chk("queue_empty", sbq.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single unified MEM between the multicycle core (port m0) and a loader/debug master (port m1).
- Serializes accesses, drives the MEM strobes (W, R), address and write data, and returns read data with a completion pulse.
- Round-robin fairness, plus an optional lock so one master can issue back-to-back accesses.
- Sits between the masters and MEM at the top level.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from the mem_R cycle to mem_rdata valid (legal 1..4).
- LOCK_MAX, 8, maximum consecutive locked grants to one master while the other is requesting.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req  in  1  access request; held until m0_done.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  AW  access address.
- m0_wdata  in  DW  write data.
- m0_lock  in  1  keep grant for the next access.
- m0_gnt  out  1  m0 owns MEM.
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data; valid when m0_done=1 for a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_done, m1_rdata  same as m0.
- mem_addr  out  AW  to MEM addr.
- mem_W  out  1  to MEM W.
- mem_R  out  1  to MEM R.
- mem_wdata  out  DW  to MEM W_data.
- mem_rdata  in  DW  from MEM R_data.
- busy  out  1  state != IDLE.
- owner  out  1  current/last owner (0=m0, 1=m1).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all gnt, done, mem_W, mem_R and busy = 0.
  - owner=0; rr pointer favours m0; hold_cnt=0; mem_addr, mem_wdata and both rdata outputs = 0.
  - Any in-flight access is abandoned; strobes drop immediately, not at the next edge.
- FSM: IDLE, ACCESS, WAIT, DONE.
- Arbitration happens in IDLE and DONE. Sample m0_req/m1_req and the winner's we/addr/wdata at the edge; these fields are latched internally for the whole access.
  - One requester: it wins.
  - Both requesting: the rr pointer winner takes the grant.
  - Lock rule: in DONE, if the current owner has lock=1 and req=1, it keeps the grant, unless the other master is requesting and hold_cnt==LOCK_MAX-1. In that case the grant is forced to the other master.
- IDLE -> ACCESS on any req; stay in IDLE otherwise.
- ACCESS, one cycle:
  - gnt of owner=1; mem_addr = latched address.
  - Write: mem_W=1, mem_wdata = latched data; next state DONE.
  - Read: mem_R=1; next state WAIT.
- WAIT, exactly RD_LAT cycles via a down-counter:
  - mem_R=0, gnt held.
  - mem_rdata captured into the owner's rdata register at the edge ending the last WAIT cycle; next state DONE.
- DONE, one cycle:
  - Owner's done=1, gnt still 1.
  - rdata holds until the owner's next read completes.
  - Re-arbitrate: next state ACCESS if any req, else IDLE. A req seen in the DONE cycle is a new request; masters drop req in the DONE cycle if they have nothing further.
- Latency, request sampled at edge 0:
  - Write: ACCESS cycle 1, DONE cycle 2.
  - Read: ACCESS cycle 1, WAIT cycles 2..1+RD_LAT, DONE cycle 2+RD_LAT.
  - Back-to-back: DONE is followed directly by ACCESS, so there is no idle bubble.
- rr pointer: after each completed non-locked access by master i, the pointer favours the other master. Locked continuations do not move the pointer.
- hold_cnt:
  - Increments on each locked continuation by the same owner.
  - Clears on owner change or on entering IDLE.
  - Saturates at LOCK_MAX-1.
- Other rules:
  - req deasserted mid-access: ignored; the access completes and done still pulses.
  - Non-owner gnt, done and rdata are never disturbed.
  - mem_W and mem_R are never both 1; neither is ever 1 outside ACCESS.
  - owner updates at the edge entering ACCESS.

Test Plan:
- Reset mid-read: assert rst=0 during WAIT -> mem_R=0, gnt=0, state IDLE immediately. After release, m0 read addr 0x10 completes normally.
- Single write then read, RD_LAT=1:
  - m0 writes 0xDEADBEEF to 0x20 -> mem_W=1 only in cycle 1; m0_done in cycle 2.
  - m0 then reads 0x20 -> mem_R=1 in cycle 1; m0_done in cycle 3 with m0_rdata=0xDEADBEEF.
- Simultaneous requests from reset, both holding req:
  - Grants alternate m0, m1, m0, m1.
  - Each done is followed by the other master's ACCESS with no IDLE cycle.
- Lock starvation cap, LOCK_MAX=8: m0 lock=1 with continuous reads, m1 req held -> m0 gets exactly 8 consecutive grants, then m1_gnt; m0's lock is not honoured on that forced switch.
- RD_LAT=3 read by m1 from 0x44 -> DONE in cycle 5; m1_rdata captured; m0_rdata unchanged.
- req dropped during WAIT -> access still completes; done pulses once; then IDLE and busy=0.
